// File: rtl/wallace_mac_sequencer.sv
// wallace_mac_sequencer
//   Drives operand pairs into an external combinational 8x8 multiplier and accumulates
//   the 16-bit products into a dot product. The pipeline has three stages:
//   accept -> product register -> accumulate.
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   start, len            begin a run of len pairs (sampled in IDLE only)
//   in_valid, in_ready    operand stream handshake; a, b are the operands
//   mul_a, mul_b          registered operands to the multiplier
//   mul_prod              combinational product mul_a*mul_b from the multiplier
//   acc_out               accumulated result (wraps modulo 2^ACC_W)
//   out_valid, out_ready  result handshake
//   busy                  high outside IDLE
//   ovf                   sticky carry-out of the accumulator during this run
module wallace_mac_sequencer #(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned ACC_W = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic [15:0]      mul_prod,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             ovf
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               v1_q, v2_q;
  logic [15:0]        prod_q;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic               accept;
  logic               clear;
  logic [ACC_W:0]     sum;

  assign accept = (state_q == StRun) && in_valid;
  assign clear  = (state_q == StIdle) && start;
  // One extra bit captures the carry out of the accumulator MSB.
  assign sum    = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, prod_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d   = len;
          state_d = (len != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        if (accept) begin
          cnt_d = cnt_q - 1'b1;
          // Exit on the last pair so the counter never underflows.
          if (cnt_q == LEN_W'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (!v1_q && !v2_q) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clear) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (v2_q) begin
      acc_d = sum[ACC_W-1:0];
      if (sum[ACC_W]) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      prod_q  <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v1_q    <= accept;
      v2_q    <= v1_q;
      prod_q  <= mul_prod;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      if (accept) begin
        mul_a <= a;
        mul_b <= b;
      end
    end
  end

  assign in_ready  = (state_q == StRun);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_wallace_mac_sequencer.sv
// tb_wallace_mac_sequencer
//   Two sequencers (ACC_W=36 and ACC_W=20) share all inputs; each has its own
//   behavioural multiplier. Results are compared against dot products computed
//   directly from the operand vectors.
module tb_wallace_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [7:0]  a, b;
  logic        out_ready;

  logic        in_ready, out_valid, busy, ovf;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_prod;
  logic [35:0] acc_out;

  logic        in_ready20, out_valid20, busy20, ovf20;
  logic [7:0]  mul_a20, mul_b20;
  logic [15:0] mul_prod20;
  logic [19:0] acc_out20;

  int checks = 0;
  int errors = 0;

  logic [7:0] va [0:255];
  logic [7:0] vb [0:255];

  always #5 clk = ~clk;

  assign mul_prod   = 16'(mul_a) * 16'(mul_b);
  assign mul_prod20 = 16'(mul_a20) * 16'(mul_b20);

  wallace_mac_sequencer #(.LEN_W(8), .ACC_W(36)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .mul_a(mul_a), .mul_b(mul_b),
    .mul_prod(mul_prod), .acc_out(acc_out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .ovf(ovf)
  );

  wallace_mac_sequencer #(.LEN_W(8), .ACC_W(20)) dut20 (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready20), .a(a), .b(b), .mul_a(mul_a20), .mul_b(mul_b20),
    .mul_prod(mul_prod20), .acc_out(acc_out20), .out_valid(out_valid20),
    .out_ready(out_ready), .busy(busy20), .ovf(ovf20)
  );

  // Dot product of the first n pairs, unbounded width.
  function automatic longint unsigned dot(input int n);
    longint unsigned s = 0;
    for (int i = 0; i < n; i++) s += longint'(va[i]) * longint'(vb[i]);
    return s;
  endfunction

  task automatic start_run(input int l);
    start = 1'b1;
    len   = 8'(l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: always valid, 1: valid every other cycle, 2: random ~70%.
  // Returns just after the edge that accepted the n-th pair.
  task automatic feed(input int n, input int mode, output int accepts);
    int idx = 0;
    int guard = 0;
    logic take;
    accepts = 0;
    while (idx < n && guard < 4000) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = guard[0] ? 1'b0 : 1'b1;
        default: in_valid = ($urandom_range(99) < 70);
      endcase
      a = va[idx];
      b = vb[idx];
      take = in_valid && in_ready;
      @(posedge clk); #1;
      if (take) begin
        idx++;
        accepts++;
      end
      guard++;
    end
    in_valid = 1'b0;
  endtask

  // Counts edges until out_valid is seen (bounded).
  task automatic wait_done(output int k);
    k = 0;
    while (!out_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; len = 0; in_valid = 0; a = 0; b = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, busy, ovf} !== 4'b0 || acc_out !== 36'd0 ||
        mul_a !== 8'd0 || mul_b !== 8'd0) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b busy=%b ovf=%b acc=%0d ma=%0d mb=%0d want all 0",
               in_ready, out_valid, busy, ovf, acc_out, mul_a, mul_b);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b rdy=%b want 0 0", busy, in_ready);
    end
  endtask

  task automatic test_basic();
    int n, k;
    longint unsigned exp;
    va[0] = 255; vb[0] = 255;
    va[1] = 1;   vb[1] = 1;
    va[2] = 10;  vb[2] = 20;
    exp = dot(3);
    start_run(3);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_run_state: rdy=%b busy=%b want 1 1", in_ready, busy);
    end
    feed(3, 0, n);
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL basic_accepts: got %0d want 3", n);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain_rdy: got %b want 0", in_ready);
    end
    wait_done(k);
    checks++;
    if (k !== 3) begin
      errors++;
      $display("FAIL basic_latency: out_valid after %0d edges want 3", k);
    end
    checks++;
    if (acc_out !== exp[35:0] || ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: acc=%0d ovf=%b want %0d 0", acc_out, ovf, exp[35:0]);
    end
    release_result();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || acc_out !== exp[35:0]) begin
      errors++;
      $display("FAIL basic_release: vld=%b busy=%b acc=%0d want 0 0 %0d",
               out_valid, busy, acc_out, exp[35:0]);
    end
  endtask

  task automatic test_len_zero();
    in_valid = 1'b1; a = 8'd5; b = 8'd5;
    start_run(0);
    checks++;
    if (out_valid !== 1'b1 || acc_out !== 36'd0 || in_ready !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL len_zero: vld=%b acc=%0d rdy=%b ovf=%b want 1 0 0 0",
               out_valid, acc_out, in_ready, ovf);
    end
    release_result();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || acc_out !== 36'd0) begin
      errors++;
      $display("FAIL len_zero_release: vld=%b rdy=%b acc=%0d want 0 0 0",
               out_valid, in_ready, acc_out);
    end
  endtask

  // Leaves the engine in DONE holding 24 for test_hold_done.
  task automatic test_bubbles();
    int n, k;
    longint unsigned exp;
    for (int i = 0; i < 4; i++) begin
      va[i] = 2; vb[i] = 3;
    end
    exp = dot(4);
    start_run(4);
    feed(4, 1, n);
    in_valid = 1'b1;  // extra pairs offered while draining must not be taken
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL bubbles_accepts: got %0d want 4", n);
    end
    wait_done(k);
    checks++;
    if (k !== 3 || acc_out !== exp[35:0]) begin
      errors++;
      $display("FAIL bubbles_result: edges=%0d acc=%0d want 3 %0d", k, acc_out, exp[35:0]);
    end
  endtask

  task automatic test_hold_done();
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      len   = 8'd7;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || acc_out !== 36'd24 || busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_done[%0d]: vld=%b acc=%0d busy=%b rdy=%b want 1 24 1 0",
                 i, out_valid, acc_out, busy, in_ready);
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    release_result();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: vld=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    int n, k;
    bit seen = 0;
    for (int i = 0; i < 5; i++) begin
      va[i] = 8'($urandom_range(1, 255)); vb[i] = 8'($urandom_range(1, 255));
    end
    start_run(5);
    feed(2, 0, n);
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, ovf} !== 4'b0 || acc_out !== 36'd0 ||
        mul_a !== 8'd0 || mul_b !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid: rdy=%b vld=%b busy=%b ovf=%b acc=%0d ma=%0d mb=%0d want all 0",
               in_ready, out_valid, busy, ovf, acc_out, mul_a, mul_b);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid || busy || acc_out != 0) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid_quiet: activity after abort, want none");
    end
    va[0] = 7; vb[0] = 9;
    start_run(1);
    feed(1, 0, n);
    wait_done(k);
    checks++;
    if (k !== 3 || acc_out !== 36'd63) begin
      errors++;
      $display("FAIL reset_mid_rerun: edges=%0d acc=%0d want 3 63", k, acc_out);
    end
    release_result();
  endtask

  task automatic test_random();
    int l, n, k, d;
    longint unsigned exp;
    for (int r = 0; r < 6; r++) begin
      l = $urandom_range(1, 24);
      for (int i = 0; i < l; i++) begin
        va[i] = 8'($urandom); vb[i] = 8'($urandom);
      end
      exp = dot(l);
      start_run(l);
      feed(l, 2, n);
      wait_done(k);
      checks++;
      if (n !== l || k !== 3) begin
        errors++;
        $display("FAIL random[%0d]_flow: accepts=%0d edges=%0d want %0d 3", r, n, k, l);
      end
      checks++;
      if (acc_out !== exp[35:0] || ovf !== (exp >= 64'h10_0000_0000)) begin
        errors++;
        $display("FAIL random[%0d]_result: acc=%0d ovf=%b want %0d %b", r, acc_out, ovf,
                 exp[35:0], exp >= 64'h10_0000_0000);
      end
      d = $urandom_range(0, 3);
      repeat (d) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || acc_out !== exp[35:0]) begin
        errors++;
        $display("FAIL random[%0d]_hold: vld=%b acc=%0d want 1 %0d", r, out_valid, acc_out,
                 exp[35:0]);
      end
      release_result();
    end
  endtask

  task automatic test_wrap();
    int n, k;
    longint unsigned exp;
    for (int i = 0; i < 255; i++) begin
      va[i] = 255; vb[i] = 255;
    end
    exp = dot(255);
    start_run(255);
    feed(255, 0, n);
    wait_done(k);
    checks++;
    if (n !== 255 || k !== 3) begin
      errors++;
      $display("FAIL wrap_flow: accepts=%0d edges=%0d want 255 3", n, k);
    end
    checks++;
    if (acc_out !== exp[35:0] || ovf !== 1'b0) begin
      errors++;
      $display("FAIL wrap_acc36: acc=%0d ovf=%b want %0d 0", acc_out, ovf, exp[35:0]);
    end
    checks++;
    if (out_valid20 !== 1'b1 || acc_out20 !== exp[19:0] || ovf20 !== (exp >= 64'h10_0000)) begin
      errors++;
      $display("FAIL wrap_acc20: vld=%b acc=%0d ovf=%b want 1 %0d %b", out_valid20, acc_out20,
               ovf20, exp[19:0], exp >= 64'h10_0000);
    end
    release_result();
    checks++;
    if (ovf20 !== 1'b1 || busy20 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_ovf_hold: ovf=%b busy=%b want 1 0", ovf20, busy20);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_bubbles();
    test_hold_done();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
